exception_sequencer: RTL and testbench
======================================

# exception_sequencer

Multi-cycle exception-entry controller for the pipelined LEG core. It picks the highest-priority pending exception each cycle and, for interrupts, drains the pipeline with a clear token. It then steps the datapath through a fixed entry sequence: save CPSR to SPSR, write LR, switch mode and mask bits, load the vector PC. It sits beside the hazard unit and drives the flush, stall and register-write strobes of the exception path.

## Interface
- SYNC_STAGES, 2: synchronizer depth for the IRQ/FIQ pins (≥2).
- DRAIN_MAX, 15: maximum number of DRAIN cycles before a forced entry.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- IRQPin, FIQPin  in  1  asynchronous external interrupt lines, level-sensitive
- IBit, FBit  in  1  live CPSR mask bits
- DataAbortM  in  1  data abort reported in M
- PrefetchAbortE, UndefinedInstrE, SWIE  in  1  synchronous exceptions reported in E
- PipelineClearM  in  1  drain token has reached M
- PipelineClearF  out  1  injects the drain token at F
- FlushD, FlushE, FlushM  out  1  stage flushes
- StallF  out  1  holds fetch
- SPSRWrite, LRWrite, ModeWrite, PCVectorLoad  out  1  entry-step strobes
- NewMode  out  5  target mode
- SetI, SetF  out  1  mask bits written with ModeWrite
- LROffset  out  4  added to the excepting instruction's PC to form LR
- VectorAddr  out  8  vector byte offset
- ExcCause  out  3  cause code: 0 none, 1 reset, 2 und, 3 swi, 4 pabt, 5 dabt, 6 irq, 7 fiq
- DrainTimeout  out  1  sticky drain-timeout flag

## Operation
- States: RST, IDLE, DRAIN, SAVE, LINK, MODE, VECTOR.
- Interrupt pins pass through a SYNC_STAGES flop chain, reset to 0. irq = IRQsync & ~IBit; fiq = FIQsync & ~FBit.
- IDLE priority: DataAbortM > fiq > IRQ > PrefetchAbortE > UndefinedInstrE > SWIE.
- Synchronous cause taken in IDLE (same cycle):
  - latch the cause;
  - assert FlushD and FlushE, plus FlushM for dabt;
  - go to SAVE.
- Interrupt taken in IDLE: latch the cause, pulse PipelineClearF for one cycle, go to DRAIN and clear the drain counter.
- DRAIN:
  - StallF=1; the counter increments each cycle.
  - If PipelineClearM is seen: assert FlushD and FlushE, go to SAVE.
  - If a synchronous exception arrives first (DataAbortM beats the E-stage causes): it replaces the latched cause, its flushes apply, go to SAVE. The interrupt is not lost; it stays level-pending.
  - When fiq rises while the latched cause is irq: the cause upgrades to fiq and the state stays DRAIN.
  - When the counter reaches DRAIN_MAX: set DrainTimeout (cleared only by reset) and go to SAVE.
- SAVE: SPSRWrite=1.
- LINK: LRWrite=1. LROffset is 8 for dabt and 4 for every other cause.
- MODE: ModeWrite=1, SetI=1. SetF=1 for fiq and reset, otherwise 0.
- NewMode by cause:
  - fiq 10001
  - irq 10010
  - swi and reset 10011
  - pabt and dabt 10111
  - und 11011
- VECTOR: PCVectorLoad=1, then go to IDLE. VectorAddr by cause:
  - reset 0x00
  - und 0x04
  - swi 0x08
  - pabt 0x0C
  - dabt 0x10
  - irq 0x18
  - fiq 0x1C
- SAVE through VECTOR: StallF=1 and FlushD=1. New events are ignored. Synchronous events are squashed by the flush; interrupts are retaken later because they are level-sensitive.
- NewMode, VectorAddr, LROffset and ExcCause hold the latched cause in every non-IDLE state and read 0 in IDLE.

## Timing
- While reset is high:
  - state is RST;
  - every output is 0 and the synchronizers are 0;
  - DrainTimeout is cleared.
- Reset release:
  - edge 1: RST→MODE with cause reset (NewMode 10011, SetI=SetF=1);
  - edge 2: MODE→VECTOR (VectorAddr 0x00);
  - edge 3: VECTOR→IDLE.
  - SAVE and LINK are skipped.
- Synchronous exception seen in IDLE at cycle N:
  - flushes in N;
  - SPSRWrite N+1, LRWrite N+2, ModeWrite N+3, PCVectorLoad N+4;
  - IDLE at N+5, where a new cause may be taken.
- Interrupt taken in IDLE at cycle N:
  - PipelineClearF in N;
  - PipelineClearM seen at cycle N+k → SAVE at N+k+1, VECTOR at N+k+4.
- IRQ pin latency: a pin rising before edge 0 is visible at the IDLE decision after edge SYNC_STAGES−1.
- Reset asserted mid-sequence forces RST immediately (asynchronously); no partial strobe persists past the reset edge.

## Test plan
- Reset release with no events → ModeWrite at cycle 1 (NewMode 10011, SetI=SetF=1), PCVectorLoad at cycle 2 with VectorAddr 0x00, IDLE at cycle 3, ExcCause 0 in IDLE.
- SWIE pulse in IDLE at N → FlushD and FlushE at N, FlushM=0; SPSRWrite N+1; LRWrite N+2 (LROffset 4); ModeWrite N+3 (NewMode 10011, SetF=0); PCVectorLoad N+4 (VectorAddr 0x08).
- DataAbortM and SWIE together → cause dabt: FlushM=1, LROffset 8, NewMode 10111, VectorAddr 0x10.
- IRQPin high with IBit=0 → PipelineClearF pulses once. PipelineClearM 3 cycles later → SAVE. Entry completes with NewMode 10010 and VectorAddr 0x18. Repeat with IBit=1 → no action.
- IRQ in DRAIN, then FIQPin rises (FBit=0) before the token arrives → cause upgrades to fiq, VectorAddr 0x1C, SetF=1. Separately, DataAbortM during DRAIN → immediate dabt entry.
- Withhold PipelineClearM with DRAIN_MAX=15 → DrainTimeout=1 after 15 DRAIN cycles and the entry completes. DrainTimeout stays 1 until reset. Reset asserted during LINK → all outputs 0 at once.

Source files
------------

// File: rtl/exception_sequencer_if.sv
// Exception-path bundle: events from the pipeline into the sequencer and the
// flush/stall/entry strobes it drives back out.
interface exception_sequencer_if;
    logic       IRQPin;
    logic       FIQPin;
    logic       IBit;
    logic       FBit;
    logic       DataAbortM;
    logic       PrefetchAbortE;
    logic       UndefinedInstrE;
    logic       SWIE;
    logic       PipelineClearM;
    logic       PipelineClearF;
    logic       FlushD;
    logic       FlushE;
    logic       FlushM;
    logic       StallF;
    logic       SPSRWrite;
    logic       LRWrite;
    logic       ModeWrite;
    logic       PCVectorLoad;
    logic [4:0] NewMode;
    logic       SetI;
    logic       SetF;
    logic [3:0] LROffset;
    logic [7:0] VectorAddr;
    logic [2:0] ExcCause;
    logic       DrainTimeout;

    // Sequencer side.
    modport slave (
        input  IRQPin, FIQPin, IBit, FBit, DataAbortM, PrefetchAbortE, UndefinedInstrE, SWIE,
        input  PipelineClearM,
        output PipelineClearF, FlushD, FlushE, FlushM, StallF, SPSRWrite, LRWrite, ModeWrite,
        output PCVectorLoad, NewMode, SetI, SetF, LROffset, VectorAddr, ExcCause, DrainTimeout
    );

    // Pipeline / datapath side.
    modport master (
        output IRQPin, FIQPin, IBit, FBit, DataAbortM, PrefetchAbortE, UndefinedInstrE, SWIE,
        output PipelineClearM,
        input  PipelineClearF, FlushD, FlushE, FlushM, StallF, SPSRWrite, LRWrite, ModeWrite,
        input  PCVectorLoad, NewMode, SetI, SetF, LROffset, VectorAddr, ExcCause, DrainTimeout
    );
endinterface

// File: rtl/exception_sequencer.sv
// Exception-entry controller: prioritises pending exceptions, drains the pipeline for
// interrupts, then steps SPSR save, LR write, mode switch and vector load.
module exception_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DRAIN_MAX   = 15
) (
    input logic                   clk,
    input logic                   reset,
    exception_sequencer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [2:0] {
        StRst, StIdle, StDrain, StSave, StLink, StMode, StVector
    } state_e;

    typedef enum logic [2:0] {
        CauseNone = 3'd0, CauseReset = 3'd1, CauseUnd = 3'd2, CauseSwi = 3'd3,
        CausePabt = 3'd4, CauseDabt = 3'd5, CauseIrq = 3'd6, CauseFiq = 3'd7
    } cause_e;

    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic [SYNC_STAGES-1:0] fiq_sync_q, fiq_sync_d;

    logic   irq, fiq;
    logic   sync_valid;
    cause_e sync_cause;

    // Shift the asynchronous interrupt pins through the synchronizer chains.
    always_comb begin
        irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], bus.IRQPin};
        fiq_sync_d = {fiq_sync_q[SYNC_STAGES-2:0], bus.FIQPin};
        irq        = irq_sync_q[SYNC_STAGES-1] & ~bus.IBit;
        fiq        = fiq_sync_q[SYNC_STAGES-1] & ~bus.FBit;
    end

    // Highest-priority synchronous cause; data abort outranks the E-stage causes.
    always_comb begin
        sync_valid = 1'b1;
        sync_cause = CauseNone;
        if (bus.DataAbortM)           sync_cause = CauseDabt;
        else if (bus.PrefetchAbortE)  sync_cause = CausePabt;
        else if (bus.UndefinedInstrE) sync_cause = CauseUnd;
        else if (bus.SWIE)            sync_cause = CauseSwi;
        else                          sync_valid = 1'b0;
    end

    // State, cause, drain counter, timeout flag and synchronizer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRst;
            cause_q    <= CauseNone;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            irq_sync_q <= '0;
            fiq_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            irq_sync_q <= irq_sync_d;
            fiq_sync_q <= fiq_sync_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d            = state_q;
        cause_d            = cause_q;
        cnt_d              = cnt_q;
        timeout_d          = timeout_q;
        bus.PipelineClearF = 1'b0;
        bus.FlushD         = 1'b0;
        bus.FlushE         = 1'b0;
        bus.FlushM         = 1'b0;
        bus.StallF         = 1'b0;
        bus.SPSRWrite      = 1'b0;
        bus.LRWrite        = 1'b0;
        bus.ModeWrite      = 1'b0;
        bus.PCVectorLoad   = 1'b0;
        bus.SetI           = 1'b0;
        bus.SetF           = 1'b0;
        unique case (state_q)
            StRst: begin
                // Reset entry skips SAVE/LINK: no prior context to preserve.
                state_d = StMode;
                cause_d = CauseReset;
            end
            StIdle: begin
                if (bus.DataAbortM) begin
                    cause_d    = CauseDabt;
                    bus.FlushD = 1'b1;
                    bus.FlushE = 1'b1;
                    bus.FlushM = 1'b1;
                    state_d    = StSave;
                end else if (fiq || irq) begin
                    cause_d            = fiq ? CauseFiq : CauseIrq;
                    bus.PipelineClearF = 1'b1;
                    cnt_d              = '0;
                    state_d            = StDrain;
                end else if (sync_valid) begin
                    cause_d    = sync_cause;
                    bus.FlushD = 1'b1;
                    bus.FlushE = 1'b1;
                    state_d    = StSave;
                end
            end
            StDrain: begin
                bus.StallF = 1'b1;
                cnt_d      = cnt_q + CntW'(1);
                if (sync_valid) begin
                    // Synchronous fault beats the token; the interrupt stays level-pending.
                    cause_d    = sync_cause;
                    bus.FlushD = 1'b1;
                    bus.FlushE = 1'b1;
                    bus.FlushM = (sync_cause == CauseDabt);
                    state_d    = StSave;
                end else begin
                    if (fiq && cause_q == CauseIrq) cause_d = CauseFiq;
                    if (bus.PipelineClearM) begin
                        bus.FlushD = 1'b1;
                        bus.FlushE = 1'b1;
                        state_d    = StSave;
                    end else if (cnt_q == CntW'(DRAIN_MAX - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = StSave;
                    end
                end
            end
            StSave: begin
                bus.StallF    = 1'b1;
                bus.FlushD    = 1'b1;
                bus.SPSRWrite = 1'b1;
                state_d       = StLink;
            end
            StLink: begin
                bus.StallF  = 1'b1;
                bus.FlushD  = 1'b1;
                bus.LRWrite = 1'b1;
                state_d     = StMode;
            end
            StMode: begin
                bus.StallF    = 1'b1;
                bus.FlushD    = 1'b1;
                bus.ModeWrite = 1'b1;
                bus.SetI      = 1'b1;
                bus.SetF      = (cause_q == CauseFiq) || (cause_q == CauseReset);
                state_d       = StVector;
            end
            StVector: begin
                bus.StallF       = 1'b1;
                bus.FlushD       = 1'b1;
                bus.PCVectorLoad = 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StRst;
        endcase
    end

    // Cause-derived outputs: valid only while an entry is in progress.
    always_comb begin
        bus.ExcCause     = 3'd0;
        bus.NewMode      = 5'b00000;
        bus.VectorAddr   = 8'h00;
        bus.LROffset     = 4'd0;
        bus.DrainTimeout = timeout_q;
        if (state_q != StIdle && state_q != StRst) begin
            bus.ExcCause = cause_q;
            bus.LROffset = (cause_q == CauseDabt) ? 4'd8 : 4'd4;
            case (cause_q)
                CauseReset: begin bus.NewMode = 5'b10011; bus.VectorAddr = 8'h00; end
                CauseUnd:   begin bus.NewMode = 5'b11011; bus.VectorAddr = 8'h04; end
                CauseSwi:   begin bus.NewMode = 5'b10011; bus.VectorAddr = 8'h08; end
                CausePabt:  begin bus.NewMode = 5'b10111; bus.VectorAddr = 8'h0C; end
                CauseDabt:  begin bus.NewMode = 5'b10111; bus.VectorAddr = 8'h10; end
                CauseIrq:   begin bus.NewMode = 5'b10010; bus.VectorAddr = 8'h18; end
                CauseFiq:   begin bus.NewMode = 5'b10001; bus.VectorAddr = 8'h1C; end
                default:    begin bus.NewMode = 5'b00000; bus.VectorAddr = 8'h00; end
            endcase
        end
    end
endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: reset entry, sync/async entries, drain timeout.
module tb_exception_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exception_sequencer_if ex ();

    exception_sequencer #(
        .SYNC_STAGES (2),
        .DRAIN_MAX   (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {PipelineClearF, FlushD, FlushE, FlushM, StallF, SPSRWrite, LRWrite, ModeWrite,
    //  PCVectorLoad, SetI, SetF}
    logic [10:0] strb;
    // {ExcCause, NewMode, VectorAddr, LROffset}
    logic [19:0] info;
    assign strb = {ex.PipelineClearF, ex.FlushD, ex.FlushE, ex.FlushM, ex.StallF, ex.SPSRWrite,
                   ex.LRWrite, ex.ModeWrite, ex.PCVectorLoad, ex.SetI, ex.SetF};
    assign info = {ex.ExcCause, ex.NewMode, ex.VectorAddr, ex.LROffset};

    localparam logic [10:0] S_NONE   = 11'b000_0000_0000;
    localparam logic [10:0] S_SAVE   = 11'b010_0110_0000;
    localparam logic [10:0] S_LINK   = 11'b010_0101_0000;
    localparam logic [10:0] S_MODE   = 11'b010_0100_1010;
    localparam logic [10:0] S_MODEF  = 11'b010_0100_1011;
    localparam logic [10:0] S_VEC    = 11'b010_0100_0100;
    localparam logic [10:0] S_SYNC   = 11'b011_0000_0000;
    localparam logic [10:0] S_DABT   = 11'b011_1000_0000;
    localparam logic [10:0] S_DDABT  = 11'b011_1100_0000;
    localparam logic [10:0] S_PCF    = 11'b100_0000_0000;
    localparam logic [10:0] S_DRAIN  = 11'b000_0100_0000;
    localparam logic [10:0] S_TOKEN  = 11'b011_0100_0000;

    localparam logic [19:0] I_NONE = 20'h0;
    localparam logic [19:0] I_RST  = {3'd1, 5'b10011, 8'h00, 4'd4};
    localparam logic [19:0] I_SWI  = {3'd3, 5'b10011, 8'h08, 4'd4};
    localparam logic [19:0] I_DABT = {3'd5, 5'b10111, 8'h10, 4'd8};
    localparam logic [19:0] I_IRQ  = {3'd6, 5'b10010, 8'h18, 4'd4};
    localparam logic [19:0] I_FIQ  = {3'd7, 5'b10001, 8'h1C, 4'd4};

    task automatic clear_inputs();
        ex.IRQPin = 0; ex.FIQPin = 0; ex.IBit = 0; ex.FBit = 0; ex.DataAbortM = 0;
        ex.PrefetchAbortE = 0; ex.UndefinedInstrE = 0; ex.SWIE = 0; ex.PipelineClearM = 0;
    endtask

    task automatic test_reset();
        logic [10:0] es [3];
        logic [19:0] ei [3];
        es = '{S_MODEF, S_VEC, S_NONE};
        ei = '{I_RST, I_RST, I_NONE};
        reset = 1'b1;
        clear_inputs();
        @(negedge clk); #1;
        checks++; if (strb !== S_NONE) begin errors++;
            $display("FAIL reset_strobes got %b exp %b", strb, S_NONE); end
        checks++; if (info !== I_NONE || ex.DrainTimeout !== 1'b0) begin errors++;
            $display("FAIL reset_info got %h/%b exp %h/0", info, ex.DrainTimeout, I_NONE); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (strb !== es[i]) begin errors++;
                $display("FAIL reset_seq%0d strobes got %b exp %b", i, strb, es[i]); end
            checks++; if (info !== ei[i]) begin errors++;
                $display("FAIL reset_seq%0d info got %h exp %h", i, info, ei[i]); end
        end
    endtask

    task automatic test_swi();
        logic [10:0] es [5];
        logic [19:0] ei [5];
        es = '{S_SAVE, S_LINK, S_MODE, S_VEC, S_NONE};
        ei = '{I_SWI, I_SWI, I_SWI, I_SWI, I_NONE};
        @(negedge clk); ex.SWIE = 1'b1; #1;
        checks++; if (strb !== S_SYNC || info !== I_NONE) begin errors++;
            $display("FAIL swi_take got %b/%h exp %b/%h", strb, info, S_SYNC, I_NONE); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); ex.SWIE = 1'b0; #1;
            checks++; if (strb !== es[i] || info !== ei[i]) begin errors++;
                $display("FAIL swi_step%0d got %b/%h exp %b/%h", i, strb, info, es[i], ei[i]); end
        end
    endtask

    task automatic test_dabt_priority();
        logic [10:0] es [5];
        logic [19:0] ei [5];
        es = '{S_SAVE, S_LINK, S_MODE, S_VEC, S_NONE};
        ei = '{I_DABT, I_DABT, I_DABT, I_DABT, I_NONE};
        @(negedge clk); ex.SWIE = 1'b1; ex.DataAbortM = 1'b1; #1;
        checks++; if (strb !== S_DABT) begin errors++;
            $display("FAIL dabt_take strobes got %b exp %b", strb, S_DABT); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); ex.SWIE = 1'b0; ex.DataAbortM = 1'b0; #1;
            checks++; if (strb !== es[i] || info !== ei[i]) begin errors++;
                $display("FAIL dabt_step%0d got %b/%h exp %b/%h", i, strb, info, es[i], ei[i]); end
        end
    endtask

    task automatic test_irq();
        logic [10:0] es [9];
        logic [19:0] ei [9];
        es = '{S_NONE, S_PCF, S_DRAIN, S_DRAIN, S_TOKEN, S_SAVE, S_LINK, S_MODE, S_VEC};
        ei = '{I_NONE, I_NONE, I_IRQ, I_IRQ, I_IRQ, I_IRQ, I_IRQ, I_IRQ, I_IRQ};
        @(negedge clk); ex.IRQPin = 1'b1; ex.IBit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ex.PipelineClearM = (i == 4);
            if (i == 4) ex.IRQPin = 1'b0;
            #1;
            checks++; if (strb !== es[i] || info !== ei[i]) begin errors++;
                $display("FAIL irq_step%0d got %b/%h exp %b/%h", i, strb, info, es[i], ei[i]); end
        end
        @(negedge clk); ex.PipelineClearM = 1'b0; #1;
        checks++; if (strb !== S_NONE || info !== I_NONE) begin errors++;
            $display("FAIL irq_idle got %b/%h exp %b/%h", strb, info, S_NONE, I_NONE); end
        // Masked interrupt: nothing happens.
        ex.IBit = 1'b1; ex.IRQPin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (strb !== S_NONE) begin errors++;
                $display("FAIL irq_masked%0d strobes got %b exp %b", i, strb, S_NONE); end
        end
        ex.IRQPin = 1'b0;
        repeat (3) @(negedge clk);
        ex.IBit = 1'b0;
    endtask

    task automatic test_fiq_upgrade();
        logic [10:0] es [8];
        logic [19:0] ei [8];
        es = '{S_DRAIN, S_DRAIN, S_TOKEN, S_SAVE, S_LINK, S_MODEF, S_VEC, S_NONE};
        ei = '{I_IRQ, I_IRQ, I_FIQ, I_FIQ, I_FIQ, I_FIQ, I_FIQ, I_NONE};
        @(negedge clk); ex.IRQPin = 1'b1;
        @(negedge clk);
        @(negedge clk); ex.FIQPin = 1'b1; #1;
        checks++; if (strb !== S_PCF) begin errors++;
            $display("FAIL fiq_irq_take strobes got %b exp %b", strb, S_PCF); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) begin ex.IRQPin = 1'b0; ex.FIQPin = 1'b0; end
            ex.PipelineClearM = (i == 2);
            #1;
            checks++; if (strb !== es[i] || info !== ei[i]) begin errors++;
                $display("FAIL fiq_step%0d got %b/%h exp %b/%h", i, strb, info, es[i], ei[i]); end
        end
    endtask

    task automatic test_dabt_in_drain();
        logic [10:0] es [7];
        logic [19:0] ei [7];
        es = '{S_DRAIN, S_DDABT, S_SAVE, S_LINK, S_MODE, S_VEC, S_NONE};
        ei = '{I_IRQ, I_IRQ, I_DABT, I_DABT, I_DABT, I_DABT, I_NONE};
        @(negedge clk); ex.IRQPin = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (strb !== S_PCF) begin errors++;
            $display("FAIL drain_dabt_take strobes got %b exp %b", strb, S_PCF); end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ex.IRQPin = 1'b0;
            ex.DataAbortM = (i == 1);
            #1;
            checks++; if (strb !== es[i] || info !== ei[i]) begin errors++;
                $display("FAIL drain_dabt_step%0d got %b/%h exp %b/%h", i, strb, info,
                         es[i], ei[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [10:0] es [5];
        es = '{S_SAVE, S_LINK, S_MODE, S_VEC, S_NONE};
        @(negedge clk); ex.IRQPin = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (strb !== S_PCF) begin errors++;
            $display("FAIL timeout_take strobes got %b exp %b", strb, S_PCF); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); ex.IRQPin = 1'b0; #1;
            checks++; if (strb !== S_DRAIN || ex.DrainTimeout !== 1'b0) begin errors++;
                $display("FAIL timeout_drain%0d got %b/%b exp %b/0", i, strb, ex.DrainTimeout,
                         S_DRAIN); end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (strb !== es[i] || ex.DrainTimeout !== 1'b1) begin errors++;
                $display("FAIL timeout_step%0d got %b/%b exp %b/1", i, strb, ex.DrainTimeout,
                         es[i]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); ex.SWIE = 1'b1;
        @(negedge clk); ex.SWIE = 1'b0;
        @(negedge clk); #1;
        checks++; if (strb !== S_LINK || ex.DrainTimeout !== 1'b1) begin errors++;
            $display("FAIL midreset_link got %b/%b exp %b/1", strb, ex.DrainTimeout, S_LINK); end
        reset = 1'b1; #1;
        checks++; if (strb !== S_NONE || info !== I_NONE || ex.DrainTimeout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %b/%h/%b exp 0", strb, info, ex.DrainTimeout); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (strb !== S_MODEF || info !== I_RST) begin errors++;
            $display("FAIL midreset_reentry got %b/%h exp %b/%h", strb, info, S_MODEF, I_RST); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_swi();
        test_dabt_priority();
        test_irq();
        test_fiq_upgrade();
        test_dabt_in_drain();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
